// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet framing constants and tx framer state encoding
package eth_pkg;

    // Shared with the receive-side preamble/SFD checker
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_PREAMBLE,
        TX_SFD,
        TX_DATA,
        TX_DROP,
        TX_IFG
    } tx_state_t;

    function automatic logic tx_state_busy(input tx_state_t s);
        return s != TX_IDLE;
    endfunction

endpackage

// File: rtl/tb_preamble_inserter_if.sv
// rtl/tb_preamble_inserter_if.sv - source byte stream and line-side signals of the tx framer
interface tb_preamble_inserter_if;

    logic [7:0] i_s_data;
    logic       i_s_valid;
    logic       i_s_last;
    logic       o_s_ready;
    logic [7:0] o_tx_word;
    logic       o_tx_en;
    logic       o_tx_err;
    logic       o_busy;

    modport master (
        output i_s_data, i_s_valid, i_s_last,
        input  o_s_ready, o_tx_word, o_tx_en, o_tx_err, o_busy
    );

    modport slave (
        input  i_s_data, i_s_valid, i_s_last,
        output o_s_ready, o_tx_word, o_tx_en, o_tx_err, o_busy
    );

endinterface

// File: rtl/tb_tx_byte_counter.sv
// rtl/tb_tx_byte_counter.sv - loadable 8-bit up counter with terminal-count compare
module tb_tx_byte_counter (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       inc,
    input  logic [7:0] tc_value,
    output logic       tc
);

    logic [7:0] count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_value;
        end else if (inc) begin
            count <= count + 8'd1;
        end
    end

    assign tc = (count == tc_value);

endmodule

// File: rtl/tb_preamble_inserter.sv
// rtl/tb_preamble_inserter.sv - tx framer: preamble, SFD, payload, enforced inter-frame gap
module tb_preamble_inserter
    import eth_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned IFG_LEN      = 12,
    parameter logic [7:0]  IDLE_WORD    = 8'h00
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    tb_preamble_inserter_if.slave  bus
);

    localparam logic [7:0] PRE_TC = 8'(PREAMBLE_LEN);
    localparam logic [7:0] IFG_TC = 8'(IFG_LEN - 1);

    tx_state_t  state, state_nxt;
    logic [7:0] word_q, word_nxt;
    logic       en_q, en_nxt;
    logic       err_q, err_nxt;
    logic       cnt_load, cnt_inc, cnt_tc;
    logic [7:0] cnt_load_value, cnt_tc_value;

    tb_tx_byte_counter u_cnt (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .inc        (cnt_inc),
        .tc_value   (cnt_tc_value),
        .tc         (cnt_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= TX_IDLE;
            word_q <= IDLE_WORD;
            en_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            word_q <= word_nxt;
            en_q   <= en_nxt;
            err_q  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        word_nxt       = word_q;
        en_nxt         = en_q;
        err_nxt        = 1'b0;
        cnt_load       = 1'b0;
        cnt_load_value = 8'd0;
        cnt_inc        = 1'b0;
        cnt_tc_value   = (state == TX_IFG) ? IFG_TC : PRE_TC;

        case (state)
            TX_IDLE: begin
                word_nxt = IDLE_WORD;
                en_nxt   = 1'b0;
                // The waiting byte is not consumed here; it is taken in DATA
                if (bus.i_s_valid) begin
                    state_nxt      = TX_PREAMBLE;
                    word_nxt       = PREAMBLE_BYTE;
                    en_nxt         = 1'b1;
                    cnt_load       = 1'b1;
                    cnt_load_value = 8'd1;
                end
            end
            TX_PREAMBLE: begin
                en_nxt = 1'b1;
                // SFD is registered on the same edge that enters DATA
                if (cnt_tc) begin
                    word_nxt  = SFD_BYTE;
                    state_nxt = TX_DATA;
                end else begin
                    word_nxt = PREAMBLE_BYTE;
                    cnt_inc  = 1'b1;
                end
            end
            TX_SFD: begin
                word_nxt  = SFD_BYTE;
                en_nxt    = 1'b1;
                state_nxt = TX_DATA;
            end
            TX_DATA: begin
                if (bus.i_s_valid) begin
                    word_nxt = bus.i_s_data;
                    en_nxt   = 1'b1;
                    if (bus.i_s_last) begin
                        state_nxt = TX_IFG;
                        cnt_load  = 1'b1;
                    end
                end else begin
                    word_nxt  = IDLE_WORD;
                    en_nxt    = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = TX_DROP;
                end
            end
            TX_DROP: begin
                word_nxt = IDLE_WORD;
                en_nxt   = 1'b0;
                if (bus.i_s_valid && bus.i_s_last) begin
                    state_nxt = TX_IFG;
                    cnt_load  = 1'b1;
                end
            end
            TX_IFG: begin
                word_nxt = IDLE_WORD;
                en_nxt   = 1'b0;
                if (cnt_tc) begin
                    state_nxt = TX_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = TX_IDLE;
                word_nxt  = IDLE_WORD;
                en_nxt    = 1'b0;
            end
        endcase
    end

    assign bus.o_s_ready = (state == TX_DATA) || (state == TX_DROP);
    assign bus.o_tx_word = word_q;
    assign bus.o_tx_en   = en_q;
    assign bus.o_tx_err  = err_q;
    assign bus.o_busy    = tx_state_busy(state);

endmodule
